// File: rtl/vga_snap_pkg.sv
// ---------------------------------------------------------------------------
// vga_snap_pkg
// Shared types and constants for the VGA register snapshot block.
//   snap_state_e      : capture FSM states (2-bit encoding)
//   SNAP_TIMEOUT_CYC  : WAIT cycles without dbg_valid before the fill word
//                       is substituted (used only with SNAP_TIMEOUT_EN)
//   SNAP_FILL         : word stored for a register whose read timed out
//   FRAME_CNT_W       : width of the completed-snapshot counter
//   TIMER_W           : width of the WAIT timeout counter
// ---------------------------------------------------------------------------
package vga_snap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    COMMIT = 2'd3
  } snap_state_e;

  localparam int          SNAP_TIMEOUT_CYC = 15;
  localparam logic [31:0] SNAP_FILL        = 32'hDEAD_BEEF;
  localparam int          FRAME_CNT_W      = 8;
  localparam int          TIMER_W          = 4;

endpackage

// File: rtl/vga_vs_edge.sv
// ---------------------------------------------------------------------------
// vga_vs_edge
// Registers the active-low VGA vertical sync and flags its falling edge.
// Ports:
//   clk_i      : clock (same domain as VS)
//   rst_i      : asynchronous active-high reset
//   vs_i       : vertical sync input, active low
//   vs_fall_o  : high for the cycle in which vs_i is low and was high on
//                the previous cycle
// The history register resets to 1 (sync inactive), so a sync that is
// already low when reset releases is not mistaken for a fresh edge.
// ---------------------------------------------------------------------------
module vga_vs_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vs_i,
  output logic vs_fall_o
);

  logic vs_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vs_q <= 1'b1;
    end else begin
      vs_q <= vs_i;
    end
  end

  assign vs_fall_o = vs_q & ~vs_i;

endmodule

// File: rtl/vga_reg_snapshot.sv
// ---------------------------------------------------------------------------
// vga_reg_snapshot
// Once per frame (falling edge of VS) reads CPU registers
// BASE_REG..BASE_REG+NREGS-1 through the debug read port into a shadow
// buffer, then publishes the whole buffer on `regfiles` in a single cycle,
// so the display never sees a half-updated register set.
//
// Ports:
//   CLK        : system/pixel clock
//   RST        : asynchronous active-high reset
//   VS         : VGA vertical sync, active low, CLK domain
//   dbg_rd     : one-cycle debug read request
//   dbg_addr   : debug read register index (holds its value outside
//                requests; qualify with dbg_rd)
//   dbg_data   : debug read data
//   dbg_valid  : one-cycle pulse qualifying dbg_data (only honoured in WAIT)
//   regfiles   : published snapshot, register i at [DW*i +: DW]
//   snap_busy  : a capture is in progress
//   frame_cnt  : completed-snapshot counter, wraps 255 -> 0
//
// Optional build macro SNAP_TIMEOUT_EN: when defined, a register whose read
// gets no dbg_valid for SNAP_TIMEOUT_CYC WAIT cycles is stored as SNAP_FILL
// and the capture moves on. Without it WAIT waits indefinitely.
// ---------------------------------------------------------------------------
module vga_reg_snapshot
  import vga_snap_pkg::*;
#(
  parameter int NREGS    = 8,
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int BASE_REG = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   VS,
  output logic                   dbg_rd,
  output logic [AW-1:0]          dbg_addr,
  input  logic [DW-1:0]          dbg_data,
  input  logic                   dbg_valid,
  output logic [NREGS*DW-1:0]    regfiles,
  output logic                   snap_busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int                IDX_W    = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NREGS - 1);

  snap_state_e            state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   dbg_rd_q, dbg_rd_d;
  logic [AW-1:0]          dbg_addr_q, dbg_addr_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [DW-1:0]          shadow_q [NREGS];
  logic [NREGS*DW-1:0]    regfiles_q;

  logic          vs_fall;
  logic          capture;    // store word_data into shadow[idx] this cycle
  logic          commit;     // copy shadow to regfiles this cycle
  logic          word_done;  // current WAIT read is finished
  logic [DW-1:0] word_data;  // value stored for the current register

  vga_vs_edge u_vs_edge (
    .clk_i     (CLK),
    .rst_i     (RST),
    .vs_i      (VS),
    .vs_fall_o (vs_fall)
  );

  // Debug address of register slot i; wraps modulo 2^AW.
  function automatic logic [AW-1:0] addr_of(input logic [IDX_W-1:0] i);
    logic [31:0] sum;
    sum = 32'(BASE_REG) + 32'(i);
    return sum[AW-1:0];
  endfunction

`ifdef SNAP_TIMEOUT_EN
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               timeout;

  // Fires on the SNAP_TIMEOUT_CYC-th consecutive WAIT cycle without data;
  // a dbg_valid in that same cycle wins and real data is stored.
  assign timeout = (state_q == WAIT) && !dbg_valid &&
                   (timer_q == TIMER_W'(SNAP_TIMEOUT_CYC - 1));

  always_comb begin
    timer_d = timer_q;
    if (state_q == REQ) begin
      timer_d = '0;
    end else if (state_q == WAIT && !dbg_valid) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign word_done = dbg_valid | timeout;
  assign word_data = dbg_valid ? dbg_data : DW'(SNAP_FILL);
`else
  assign word_done = dbg_valid;
  assign word_data = dbg_data;
`endif

  // NOTE: every variable driven here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dbg_rd_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
    capture     = 1'b0;
    commit      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Edges seen in any other state are dropped, not queued.
        if (vs_fall) begin
          idx_d    = '0;
          dbg_rd_d = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (word_done) begin
          capture = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = COMMIT;
          end else begin
            idx_d    = idx_q + 1'b1;
            dbg_rd_d = 1'b1;
            state_d  = REQ;
          end
        end
      end
      COMMIT: begin
        commit      = 1'b1;
        frame_cnt_d = frame_cnt_q + 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // dbg_rd and dbg_addr are registered and loaded on entry to REQ so
    // they are clean flop outputs during the REQ cycle.
    dbg_addr_d = dbg_rd_d ? addr_of(idx_d) : dbg_addr_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      dbg_rd_q    <= 1'b0;
      dbg_addr_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dbg_rd_q    <= dbg_rd_d;
      dbg_addr_q  <= dbg_addr_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // NOTE: the shadow buffer is reset on purpose: a reset must also drop any
  // partially captured frame, and the flops are small enough that clearing
  // them costs nothing compared to a RAM.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) begin
        shadow_q[i] <= '0;
      end
      regfiles_q <= '0;
    end else begin
      if (capture) begin
        shadow_q[idx_q] <= word_data;
      end
      // All words move together, so regfiles never mixes two snapshots.
      if (commit) begin
        for (int j = 0; j < NREGS; j++) begin
          regfiles_q[DW*j +: DW] <= shadow_q[j];
        end
      end
    end
  end

  assign dbg_rd    = dbg_rd_q;
  assign dbg_addr  = dbg_addr_q;
  assign regfiles  = regfiles_q;
  assign snap_busy = (state_q != IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_reg_snapshot.sv
// ---------------------------------------------------------------------------
// tb_vga_reg_snapshot
// Two instances: u_dut0 (BASE_REG=0) and u_dut8 (BASE_REG=8) share clock,
// reset and VS. A behavioural debug-port responder per instance answers
// each read after a configurable latency and records what it returned; the
// expected snapshot is simply "the last word supplied for each address".
// Build with SNAP_TIMEOUT_EN defined to exercise the timeout fill path.
// ---------------------------------------------------------------------------
module tb_vga_reg_snapshot;
  import vga_snap_pkg::*;

  localparam int NREGS = 8;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int FLAT  = NREGS * DW;
  localparam int LOG_N = 4096;

  logic CLK = 1'b0;
  logic RST;
  logic VS;

  logic                   dbg_rd    [2];
  logic [AW-1:0]          dbg_addr  [2];
  logic [DW-1:0]          dbg_data  [2];
  logic                   dbg_valid [2];
  logic [FLAT-1:0]        regfiles  [2];
  logic                   snap_busy [2];
  logic [FRAME_CNT_W-1:0] frame_cnt [2];

  int checks   = 0;
  int failures = 0;

  // Responder configuration (written by the stimulus process only).
  int lat_min;
  int lat_max;
  bit rand_data;
  int mute_addr [2];

  // Responder state (written by the responder process only).
  int            countdown [2];
  logic [AW-1:0] pend_addr [2];
  logic [DW-1:0] exp_w     [2][NREGS];
  int            addr_log  [2][LOG_N];
  int            addr_n    [2];

  // Expected published state (written by the stimulus process only).
  logic [FLAT-1:0] pub_exp [2];
  int              frame_exp;

  always #5 CLK = ~CLK;

  vga_reg_snapshot #(.NREGS(NREGS), .DW(DW), .AW(AW), .BASE_REG(0)) u_dut0 (
    .CLK       (CLK),
    .RST       (RST),
    .VS        (VS),
    .dbg_rd    (dbg_rd[0]),
    .dbg_addr  (dbg_addr[0]),
    .dbg_data  (dbg_data[0]),
    .dbg_valid (dbg_valid[0]),
    .regfiles  (regfiles[0]),
    .snap_busy (snap_busy[0]),
    .frame_cnt (frame_cnt[0])
  );

  vga_reg_snapshot #(.NREGS(NREGS), .DW(DW), .AW(AW), .BASE_REG(8)) u_dut8 (
    .CLK       (CLK),
    .RST       (RST),
    .VS        (VS),
    .dbg_rd    (dbg_rd[1]),
    .dbg_addr  (dbg_addr[1]),
    .dbg_data  (dbg_data[1]),
    .dbg_valid (dbg_valid[1]),
    .regfiles  (regfiles[1]),
    .snap_busy (snap_busy[1]),
    .frame_cnt (frame_cnt[1])
  );

  function automatic int base_of(input int g);
    return (g == 0) ? 0 : 8;
  endfunction

  function automatic logic [FLAT-1:0] flat_of(input int g);
    logic [FLAT-1:0] v;
    v = '0;
    for (int j = 0; j < NREGS; j++) begin
      v[DW*j +: DW] = exp_w[g][j];
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [FLAT-1:0] obs,
                       input logic [FLAT-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Debug-port responder: acts 1 time unit after each rising edge.
  initial begin
    for (int g = 0; g < 2; g++) begin
      dbg_valid[g] = 1'b0;
      dbg_data[g]  = '0;
      countdown[g] = 0;
      pend_addr[g] = '0;
      addr_n[g]    = 0;
      for (int j = 0; j < NREGS; j++) exp_w[g][j] = '0;
    end
    forever begin
      @(posedge CLK);
      #1;
      for (int g = 0; g < 2; g++) begin
        int slot;
        dbg_valid[g] = 1'b0;
        if (RST) begin
          countdown[g] = 0;
          continue;
        end
        if (countdown[g] > 0) begin
          countdown[g]--;
          if (countdown[g] == 0) begin
            dbg_valid[g] = 1'b1;
            dbg_data[g]  = rand_data ? DW'($urandom) : 32'h1000_0000 + 32'(pend_addr[g]);
            slot = int'(pend_addr[g]) - base_of(g);
            if (slot >= 0 && slot < NREGS) exp_w[g][slot] = dbg_data[g];
          end
        end
        if (dbg_rd[g]) begin
          addr_log[g][addr_n[g] % LOG_N] = int'(dbg_addr[g]);
          addr_n[g]++;
          pend_addr[g] = dbg_addr[g];
          if (int'(dbg_addr[g]) == mute_addr[g]) begin
`ifdef SNAP_TIMEOUT_EN
            slot = int'(dbg_addr[g]) - base_of(g);
            if (slot >= 0 && slot < NREGS) exp_w[g][slot] = DW'(SNAP_FILL);
`endif
          end else begin
            countdown[g] = int'($urandom_range(lat_max, lat_min));
          end
        end
      end
    end
  end

  // Drives one VS falling edge at the current negedge (cycle t0) and
  // follows the capture to completion. cyc returns k where the first idle
  // cycle seen is t0+k. glitch!=0 re-raises VS at t0+3 and drops it again
  // at t0+5, which must not start a second capture.
  task automatic run_frame(input bit chk_stable, input bit glitch, output int cyc);
    int start_n [2];
    bit done;
    for (int g = 0; g < 2; g++) start_n[g] = addr_n[g];
    VS   = 1'b0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge CLK);
      cyc++;
      if (glitch && cyc == 3) VS = 1'b1;
      if (glitch && cyc == 5) VS = 1'b0;
      if (cyc == 1) begin
        for (int g = 0; g < 2; g++) begin
          check($sformatf("req0_rd_g%0d", g), dbg_rd[g], 1'b1);
          check($sformatf("req0_addr_g%0d", g), dbg_addr[g], base_of(g));
          check($sformatf("req0_busy_g%0d", g), snap_busy[g], 1'b1);
        end
      end
      done = !snap_busy[0] && !snap_busy[1];
      if (chk_stable) begin
        for (int g = 0; g < 2; g++) begin
          if (snap_busy[g]) check($sformatf("stable_g%0d", g), regfiles[g], pub_exp[g]);
        end
      end
    end
    check("frame_done", done, 1'b1);
    frame_exp = (frame_exp + 1) % 256;
    for (int g = 0; g < 2; g++) begin
      pub_exp[g] = flat_of(g);
      check($sformatf("regfiles_g%0d", g), regfiles[g], pub_exp[g]);
      check($sformatf("frame_cnt_g%0d", g), frame_cnt[g], frame_exp);
      check($sformatf("nreq_g%0d", g), addr_n[g] - start_n[g], NREGS);
      for (int j = 0; j < NREGS; j++) begin
        check($sformatf("addr_seq_g%0d_%0d", g, j),
              addr_log[g][(start_n[g] + j) % LOG_N], base_of(g) + j);
      end
    end
    // VS is still low here: no second capture may start.
    @(negedge CLK);
    for (int g = 0; g < 2; g++) check($sformatf("no_retrig_g%0d", g), snap_busy[g], 1'b0);
    VS = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    RST          = 1'b1;
    VS           = 1'b1;
    lat_min      = 1;
    lat_max      = 1;
    rand_data    = 1'b0;
    mute_addr[0] = -1;
    mute_addr[1] = -1;
    frame_exp    = 0;
    pub_exp[0]   = '0;
    pub_exp[1]   = '0;

    repeat (3) @(negedge CLK);
    for (int g = 0; g < 2; g++) begin
      check("rst_regfiles", regfiles[g], '0);
      check("rst_dbg_rd", dbg_rd[g], 1'b0);
      check("rst_dbg_addr", dbg_addr[g], '0);
      check("rst_busy", snap_busy[g], 1'b0);
      check("rst_frame_cnt", frame_cnt[g], '0);
    end
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // 1-cycle responder, fixed data: commit at t0+17, visible at t0+18.
    run_frame(1'b1, 1'b0, cyc);
    check("lat1_cycles", cyc, 18);
    check("lat1_word0", regfiles[0][31:0], 32'h1000_0000);
    check("lat1_word7", regfiles[0][255:224], 32'h1000_0007);
    check("lat1_frame_cnt", frame_cnt[0], 1);

    // 3-cycle responder, random data: regfiles must hold the old snapshot.
    lat_min   = 3;
    lat_max   = 3;
    rand_data = 1'b1;
    run_frame(1'b1, 1'b0, cyc);
    check("lat3_cycles", cyc, 34);

    // Second falling edge at t0+5 during a capture is ignored.
    lat_min = 1;
    lat_max = 1;
    run_frame(1'b1, 1'b1, cyc);
    repeat (30) @(negedge CLK);
    for (int g = 0; g < 2; g++) begin
      check("glitch_idle", snap_busy[g], 1'b0);
      check("glitch_frame_cnt", frame_cnt[g], frame_exp);
    end

    // Reset at t0+9: everything clears asynchronously, no commit.
    VS = 1'b0;
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      check("midrst_regfiles", regfiles[g], '0);
      check("midrst_dbg_rd", dbg_rd[g], 1'b0);
      check("midrst_busy", snap_busy[g], 1'b0);
      check("midrst_frame_cnt", frame_cnt[g], '0);
      pub_exp[g] = '0;
    end
    frame_exp = 0;
    @(negedge CLK);
    VS = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    run_frame(1'b1, 1'b0, cyc);

    // 256 frames with random latency and data: frame_cnt wraps 255 -> 0.
    lat_min = 1;
    lat_max = 4;
    for (int f = 0; f < 256; f++) begin
      run_frame(1'b1, 1'b0, cyc);
    end
    check("wrap_frame_cnt", frame_cnt[0], 8'd1);

    // Register at slot 3 never answered.
    mute_addr[0] = 3;
    mute_addr[1] = 11;
`ifdef SNAP_TIMEOUT_EN
    run_frame(1'b1, 1'b0, cyc);
    check("timeout_word3_g0", regfiles[0][127:96], 32'hDEAD_BEEF);
    check("timeout_word3_g1", regfiles[1][127:96], 32'hDEAD_BEEF);
`else
    VS = 1'b0;
    repeat (100) @(negedge CLK);
    for (int g = 0; g < 2; g++) begin
      check("stuck_busy", snap_busy[g], 1'b1);
      check("stuck_regfiles", regfiles[g], pub_exp[g]);
    end
    RST = 1'b1;
    @(negedge CLK);
    VS  = 1'b1;
    RST = 1'b0;
    for (int g = 0; g < 2; g++) pub_exp[g] = '0;
    frame_exp = 0;
    @(negedge CLK);
`endif
    mute_addr[0] = -1;
    mute_addr[1] = -1;
    run_frame(1'b1, 1'b0, cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_reg_snapshot.md
Name: vga_reg_snapshot

Overview:
- Upstream feeder for the VGA register display. Copies CPU registers BASE_REG..BASE_REG+NREGS-1 through the CPU debug read port into a shadow buffer.
- Publishes the buffer as one flat bus (`regfiles`) atomically, once per frame, on the falling edge of the VGA vertical sync.
- Atomic publication means the display never shows a half-updated register set.

Parameters:
- NREGS, 8: registers captured per frame.
- DW, 32: register width.
- AW, 5: debug address width.
- BASE_REG, 0: index of the first CPU register captured.

Ports:
- CLK  in  1  system/pixel clock.
- RST  in  1  asynchronous, active-high reset.
- VS  in  1  VGA vertical sync, active low, same clock domain.
- dbg_rd  out  1  debug read request, one-cycle pulse.
- dbg_addr  out  AW  debug read register index.
- dbg_data  in  DW  debug read data.
- dbg_valid  in  1  dbg_data valid, one-cycle pulse.
- regfiles  out  NREGS*DW  published snapshot; reg i at [DW*i+DW-1 : DW*i].
- snap_busy  out  1  capture in progress.
- frame_cnt  out  8  completed-snapshot counter.

Behaviour:
- Interface: one clock (CLK); RST is asynchronous and active-high.
- Reset values: regfiles=0, shadow=0, idx=0, dbg_rd=0, dbg_addr=0, snap_busy=0, frame_cnt=0, state=IDLE, vs_q=1.
- VS edge: vs_q <= VS each cycle; vs_fall = vs_q & ~VS.
- IDLE: on vs_fall -> REQ with idx=0, snap_busy=1. vs_fall in any other state is ignored (no queuing).
- REQ (1 cycle): dbg_rd=1, dbg_addr=BASE_REG+idx (AW bits, modulo 2^AW) -> WAIT.
- WAIT:
  - dbg_rd=0. dbg_valid is sampled only in WAIT; dbg_valid in IDLE/REQ/COMMIT is ignored.
  - On dbg_valid: shadow[idx] <= dbg_data.
  - If idx==NREGS-1 -> COMMIT; else idx+1 -> REQ.
- COMMIT (1 cycle):
  - regfiles <= shadow (all NREGS words in the same cycle).
  - frame_cnt+1, wrapping 255->0.
  - -> IDLE; snap_busy=0 from the next cycle.
- Latency: with a 1-cycle debug response, edge cycle = t0:
  - REQ idx0 at t0+1.
  - COMMIT at t0+17.
  - New regfiles visible at t0+18.
- regfiles is stable outside COMMIT; it never mixes data from two snapshots.
- Reset mid-capture: everything returns to reset values immediately. regfiles=0 even if a previous snapshot existed. No COMMIT occurs.
- VS held low: only one capture per falling edge.
- dbg_addr holds its last value outside REQ; consumers must qualify it with dbg_rd.

Optional Feature:
- Macro SNAP_TIMEOUT_EN.
- When defined:
  - A 4-bit counter runs in WAIT.
  - If dbg_valid is absent for 15 cycles, shadow[idx] <= 32'hDEAD_BEEF and the FSM proceeds as if valid arrived.
  - The counter clears on every REQ.
  - A dbg_valid in the same cycle as the timeout takes priority: real data is stored.
- When undefined: WAIT waits indefinitely, with no counter logic.

Decomposition:
- Package vga_snap_pkg:
  - state enum {IDLE, REQ, WAIT, COMMIT} (2-bit).
  - SNAP_TIMEOUT_CYC=15.
  - SNAP_FILL=32'hDEAD_BEEF.
  - FRAME_CNT_W=8.
- Sub-module vga_vs_edge: registers VS and outputs a vs_fall pulse; vs_q resets to 1 so no false edge occurs after reset.
- FSM and buffers stay in vga_reg_snapshot.

Test Plan:
- Reset, then VS 1->0; debug model answers reg i with 32'h1000_0000+i after 1 cycle -> regfiles[31:0]=32'h1000_0000, regfiles[255:224]=32'h1000_0007; visible 18 cycles after the edge; frame_cnt=1; snap_busy low afterwards.
- Debug latency 3 cycles and data changed mid-capture -> regfiles updates only at COMMIT; sampled every cycle during capture it equals the old snapshot exactly.
- Second VS falling edge at t0+5 during a capture -> ignored; exactly one COMMIT; frame_cnt increments by 1.
- Assert RST at t0+9 -> regfiles=0, dbg_rd=0, snap_busy=0 asynchronously; next VS edge restarts at idx0 with dbg_addr=BASE_REG.
- Run 256 frames -> frame_cnt wraps 255->0; BASE_REG=8 gives dbg_addr sequence 8..15.
- SNAP_TIMEOUT_EN defined, reg 3 never answered -> regfiles[127:96]=32'hDEAD_BEEF and the other words are correct; with the macro undefined, FSM stays in WAIT and snap_busy stays 1.
